// File: rtl/text_banner_render.sv
// Renders a runtime-writable string of glyphs at a movable origin with integer pixel scaling.
// Supports static, blink and typewriter-reveal display modes, all paced by frame ticks.
module text_banner_render #(
    parameter int N_CHARS      = 8,
    parameter int GLYPH_W      = 5,
    parameter int GLYPH_H      = 7,
    parameter int SCALE_LOG2   = 2,
    parameter int PITCH        = 31,
    parameter int BLINK_FRAMES = 30,
    parameter int TYPE_FRAMES  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [9:0]                 start_x,
    input  logic [9:0]                 start_y,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    input  logic                       frame_tick,
    input  logic [1:0]                 mode,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_idx,
    input  logic [5:0]                 wr_code,
    output logic [5:0]                 glyph_code,
    output logic [2:0]                 glyph_row,
    input  logic [GLYPH_W-1:0]         glyph_bits,
    output logic                       display,
    output logic                       done
);

    localparam int IDX_W = $clog2(N_CHARS);
    localparam int REV_W = $clog2(N_CHARS + 1);
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TC_W  = (TYPE_FRAMES > 1) ? $clog2(TYPE_FRAMES) : 1;
    localparam logic [10:0] PX_W      = 11'(GLYPH_W << SCALE_LOG2);
    localparam logic [10:0] PX_H      = 11'(GLYPH_H << SCALE_LOG2);
    localparam logic [10:0] LAST_COL  = 11'(GLYPH_W - 1);
    localparam logic [10:0] SCREEN_LIM = 11'd1024;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_TYPE   = 2'b10,
        MODE_ALT    = 2'b11
    } mode_t;

    logic [5:0]         slot_q [N_CHARS];
    logic [5:0]         slot_d [N_CHARS];
    logic [10:0]        dx_vec [N_CHARS];
    logic [N_CHARS-1:0] hit_vec;

    logic [10:0] dy;
    logic        y_in;

    // Extend to 11 bits so origins past the right screen edge never alias back.
    assign dy   = {1'b0, y} - {1'b0, start_y};
    assign y_in = ({1'b0, y} >= {1'b0, start_y}) && (dy < PX_H);

    genvar gi;
    generate
        for (gi = 0; gi < N_CHARS; gi++) begin : g_slot
            logic [10:0] origin;
            assign origin      = {1'b0, start_x} + 11'(gi * PITCH);
            assign dx_vec[gi]  = {1'b0, x} - origin;
            assign hit_vec[gi] = (origin < SCREEN_LIM) && ({1'b0, x} >= origin)
                                 && (dx_vec[gi] < PX_W) && y_in;

            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (wr_en && (32'(wr_idx) == gi)) begin
                    slot_d[gi] = wr_code;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q[gi] <= 6'd0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [10:0]      hit_dx;
    logic [10:0]      col;
    logic [10:0]      bit_sel;
    logic [GLYPH_W-1:0] row_shift;
    logic             pix;

    // Scan from the top index down so the lowest overlapping slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_dx  = '0;
        for (int i = N_CHARS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_dx  = dx_vec[i];
            end
        end
    end

    assign glyph_code = hit ? slot_q[hit_idx] : 6'd0;
    assign glyph_row  = 3'(dy >> SCALE_LOG2);
    assign col        = hit_dx >> SCALE_LOG2;
    assign bit_sel    = LAST_COL - col;
    assign row_shift  = glyph_bits >> bit_sel;
    assign pix        = hit && (glyph_code != 6'd0) && row_shift[0];

    logic [1:0]       mode_q, mode_d;
    logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_vis_q, blink_vis_d;
    logic [TC_W-1:0]  type_cnt_q, type_cnt_d;
    logic [REV_W-1:0] reveal_q, reveal_d;
    logic             done_q, done_d;
    logic             display_q, display_d;
    logic             visible;

    always_comb begin
        mode_d      = mode;
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        type_cnt_d  = type_cnt_q;
        reveal_d    = reveal_q;
        visible     = 1'b1;

        case (mode_t'(mode))
            MODE_BLINK: visible = blink_vis_q;
            MODE_TYPE:  visible = REV_W'(hit_idx) < reveal_q;
            default:    visible = 1'b1;
        endcase

        // A mode switch restarts the animation and swallows any coincident tick.
        if (mode != mode_q) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
            type_cnt_d  = '0;
            reveal_d    = '0;
        end else if (frame_tick) begin
            case (mode_t'(mode))
                MODE_BLINK: begin
                    if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d = '0;
                        blink_vis_d = ~blink_vis_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                MODE_TYPE: begin
                    if (type_cnt_q == TC_W'(TYPE_FRAMES - 1)) begin
                        type_cnt_d = '0;
                        if (reveal_q != REV_W'(N_CHARS)) begin
                            reveal_d = reveal_q + 1'b1;
                        end
                    end else begin
                        type_cnt_d = type_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        done_d    = (reveal_d == REV_W'(N_CHARS));
        display_d = pix && visible;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 2'b00;
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
            type_cnt_q  <= '0;
            reveal_q    <= '0;
            done_q      <= 1'b0;
            display_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            type_cnt_q  <= type_cnt_d;
            reveal_q    <= reveal_d;
            done_q      <= done_d;
            display_q   <= display_d;
        end
    end

    assign display = display_q;
    assign done    = done_q;

endmodule

// File: tb/tb_text_banner_render.sv
// Randomised self-checking bench for text_banner_render against a tick-count reference model.
// Built with overlapping slots (PITCH < glyph width) and short blink/typewriter periods.
module tb_text_banner_render;

    localparam int N     = 8;
    localparam int GW    = 5;
    localparam int GH    = 7;
    localparam int S     = 2;
    localparam int PITCH = 18;
    localparam int BLINK = 2;
    localparam int TYPE  = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   start_x = 10'd100;
    logic [9:0]   start_y = 10'd50;
    logic [9:0]   x = '0;
    logic [9:0]   y = '0;
    logic         frame_tick = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_idx = '0;
    logic [5:0]   wr_code = '0;
    logic [5:0]   glyph_code;
    logic [2:0]   glyph_row;
    logic [GW-1:0] glyph_bits;
    logic         display;
    logic         done;

    int errors = 0;
    int checks = 0;

    int m_slot [N];
    int m_mode_q = 0;
    int m_ticks = 0;

    always #5 clk = ~clk;

    // External font ROM: column 0 always lit, other columns vary with code and row.
    function automatic logic [GW-1:0] rom(input logic [5:0] c, input logic [2:0] r);
        logic [5:0] t;
        t = c * 6'd13 + {3'b000, r} * 6'd7 + 6'd5;
        return {1'b1, t[3:0]};
    endfunction

    assign glyph_bits = rom(glyph_code, glyph_row);

    text_banner_render #(
        .N_CHARS(N), .GLYPH_W(GW), .GLYPH_H(GH), .SCALE_LOG2(S),
        .PITCH(PITCH), .BLINK_FRAMES(BLINK), .TYPE_FRAMES(TYPE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_x(start_x), .start_y(start_y),
        .x(x), .y(y), .frame_tick(frame_tick), .mode(mode),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
        .glyph_code(glyph_code), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
        .display(display), .done(done)
    );

    function automatic int model_hit(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            int org;
            org = int'(start_x) + i * PITCH;
            if (px >= org && px < org + GW * (1 << S) &&
                py >= int'(start_y) && py < int'(start_y) + GH * (1 << S))
                return i;
        end
        return -1;
    endfunction

    function automatic int model_code(input int px, input int py);
        int h;
        h = model_hit(px, py);
        return (h < 0) ? 0 : m_slot[h];
    endfunction

    function automatic bit model_pix(input int px, input int py);
        int h, org, col;
        logic [GW-1:0] b;
        h = model_hit(px, py);
        if (h < 0 || m_slot[h] == 0) return 1'b0;
        org = int'(start_x) + h * PITCH;
        col = (px - org) >> S;
        b = rom(6'(m_slot[h]), 3'((py - int'(start_y)) >> S));
        return b[GW - 1 - col];
    endfunction

    function automatic bit model_vis(input int h);
        int t, rev;
        t = (int'(mode) == m_mode_q) ? m_ticks : 0;
        rev = (t / TYPE > N) ? N : t / TYPE;
        case (int'(mode))
            1: return ((t / BLINK) % 2) == 0;
            2: return h < rev;
            default: return 1'b1;
        endcase
    endfunction

    // Advances the model across one clock edge and returns the outputs expected after it.
    task automatic clk_step(output bit exp_disp, output bit exp_done);
        int h;
        h = model_hit(int'(x), int'(y));
        exp_disp = model_pix(int'(x), int'(y)) && model_vis(h);
        if (int'(mode) != m_mode_q) m_ticks = 0;
        else if (frame_tick && (mode == 2'b01 || mode == 2'b10)) m_ticks++;
        m_mode_q = int'(mode);
        if (wr_en && int'(wr_idx) < N) m_slot[wr_idx] = int'(wr_code);
        exp_done = (m_mode_q == 2) && ((m_ticks / TYPE) >= N);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_slot[i] = 0;
        m_mode_q = 0;
        m_ticks = 0;
    endtask

    task automatic write_slot(input int idx, input int code);
        bit ed, en;
        wr_en = 1'b1;
        wr_idx = 3'(idx);
        wr_code = 6'(code);
        clk_step(ed, en);
    endtask

    task automatic test_reset();
        bit ed, en;
        rst_n = 1'b0;
        model_reset();
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (display !== 1'b0) begin errors++; $display("FAIL reset_display got=%b want=0", display); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        x = 10'd102; y = 10'd50;
        #1;
        checks++;
        if (glyph_code !== 6'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", glyph_code); end
        clk_step(ed, en);
        checks++;
        if (display !== ed) begin errors++; $display("FAIL reset_blank got=%b want=%b", display, ed); end
    endtask

    task automatic test_static();
        bit ed, en;
        int xs [6] = '{100, 104, 108, 100 + PITCH + 2, 100, 99};
        int ys [6] = '{50, 50, 50, 50, 78, 50};
        mode = 2'b00;
        start_x = 10'd100; start_y = 10'd50;
        write_slot(0, 4); write_slot(1, 18); write_slot(2, 1); write_slot(3, 23);
        write_slot(4, 1 + $urandom_range(62)); write_slot(6, 1 + $urandom_range(62));
        write_slot(7, 1 + $urandom_range(62));
        for (int i = 0; i < 46; i++) begin
            if (i < 6) begin
                x = 10'(xs[i]); y = 10'(ys[i]);
            end else begin
                x = 10'(95 + $urandom_range(N * PITCH + 10));
                y = 10'(45 + $urandom_range(40));
            end
            #1;
            checks++;
            if (glyph_code !== 6'(model_code(int'(x), int'(y)))) begin
                errors++;
                $display("FAIL static_code x=%0d y=%0d got=%0d want=%0d", x, y, glyph_code, model_code(int'(x), int'(y)));
            end
            clk_step(ed, en);
            checks++;
            if (display !== ed) begin
                errors++;
                $display("FAIL static_display x=%0d y=%0d got=%b want=%b", x, y, display, ed);
            end
        end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) begin
            x = 10'(100 + PITCH + (i % 2));
            y = 10'(50 + $urandom_range(27));
            #1;
            checks++;
            if (glyph_code !== 6'(m_slot[0])) begin
                errors++;
                $display("FAIL overlap_code x=%0d got=%0d want=%0d", x, glyph_code, m_slot[0]);
            end
        end
    endtask

    task automatic test_edge();
        bit ed, en;
        start_x = 10'd1000; start_y = 10'd200;
        for (int i = 0; i < 20; i++) begin
            x = (i == 0) ? 10'd1023 : 10'(1000 + $urandom_range(23));
            y = 10'(200 + $urandom_range(27));
            #1;
            checks++;
            if (glyph_code !== 6'(model_code(int'(x), int'(y)))) begin
                errors++;
                $display("FAIL edge_code x=%0d y=%0d got=%0d want=%0d", x, y, glyph_code, model_code(int'(x), int'(y)));
            end
            clk_step(ed, en);
            checks++;
            if (display !== ed) begin
                errors++;
                $display("FAIL edge_display x=%0d y=%0d got=%b want=%b", x, y, display, ed);
            end
        end
        start_x = 10'd100; start_y = 10'd50;
    endtask

    task automatic test_write_same_cycle();
        bit ed, en;
        x = 10'd102; y = 10'd50;
        wr_en = 1'b1; wr_idx = 3'd0; wr_code = 6'd0;
        clk_step(ed, en);
        checks++;
        if (display !== ed || ed !== 1'b1) begin errors++; $display("FAIL write_old_code got=%b want=1", display); end
        clk_step(ed, en);
        checks++;
        if (display !== ed) begin errors++; $display("FAIL write_new_code got=%b want=%b", display, ed); end
        write_slot(0, 9);
    endtask

    task automatic test_blink();
        bit ed, en;
        mode = 2'b01;
        x = 10'd102; y = 10'd50;
        for (int i = 0; i < 40; i++) begin
            frame_tick = ($urandom_range(2) == 0);
            clk_step(ed, en);
            checks++;
            if (display !== ed || done !== en) begin
                errors++;
                $display("FAIL blink cyc=%0d display=%b want=%b done=%b want=%b", i, display, ed, done, en);
            end
        end
    endtask

    task automatic test_typewriter();
        bit ed, en;
        mode = 2'b10;
        y = 10'd50;
        for (int i = 0; i < 60; i++) begin
            x = 10'(100 + (i % N) * PITCH + 2);
            frame_tick = ($urandom_range(1) == 0);
            clk_step(ed, en);
            checks++;
            if (display !== ed || done !== en) begin
                errors++;
                $display("FAIL typewriter cyc=%0d display=%b want=%b done=%b want=%b", i, display, ed, done, en);
            end
        end
    endtask

    task automatic test_mode_change_tick();
        bit ed, en;
        x = 10'd102; y = 10'd50;
        mode = 2'b00; frame_tick = 1'b1;
        clk_step(ed, en);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL modechg_done got=%b want=0", done); end
        mode = 2'b10; frame_tick = 1'b1;
        clk_step(ed, en);
        checks++;
        if (done !== en) begin errors++; $display("FAIL modechg_done2 got=%b want=%b", done, en); end
        for (int i = 0; i < 4; i++) begin
            frame_tick = (i == 2);
            clk_step(ed, en);
            checks++;
            if (display !== ed) begin
                errors++;
                $display("FAIL modechg_reveal cyc=%0d got=%b want=%b", i, display, ed);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ed, en;
        mode = 2'b00;
        x = 10'd102; y = 10'd50;
        clk_step(ed, en);
        clk_step(ed, en);
        checks++;
        if (display !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b want=1", display); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (display !== 1'b0) begin errors++; $display("FAIL areset_async got=%b want=0", display); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (glyph_code !== 6'd0) begin errors++; $display("FAIL areset_code got=%0d want=0", glyph_code); end
            clk_step(ed, en);
            checks++;
            if (display !== ed) begin errors++; $display("FAIL areset_display got=%b want=%b", display, ed); end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_overlap();
        test_edge();
        test_write_same_cycle();
        test_blink();
        test_typewriter();
        test_mode_change_tick();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
